trace_readout_sequencer: RTL and testbench

- Host-side controller for the stream trace buffer peripheral.
- Accepts one capture command, writes the control word over the buffer's control ready/valid port, then polls the status port until the trigger flag is set.
- Then drains a commanded number of trace words from the buffer's data-out port into a downstream sink, with last-word marking, timeout and abort.
- Sequences one capture/readout at a time; sits between the debug host logic and the peripheral.

---
 rtl/trace_readout_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_trace_readout_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_readout_sequencer.sv
// Host-side sequencer for the stream trace buffer: writes one control word, polls
// status for the trigger flag, then drains a commanded number of words to a sink.
`timescale 1ns/1ps
module trace_readout_sequencer #(
    parameter int CTRL_W         = 8,
    parameter int STAT_W         = 8,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TRIG_BIT       = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CMD_VALID_I,
    output logic              CMD_READY_O,
    input  logic [CTRL_W-1:0] CMD_CONTROL_I,
    input  logic [CNT_W-1:0]  CMD_WORDS_I,
    input  logic              ABORT_I,
    output logic              CONTROL_VALID_O,
    input  logic              CONTROL_READY_I,
    output logic [CTRL_W-1:0] CONTROL_O,
    input  logic              STATUS_VALID_I,
    output logic              STATUS_READY_O,
    input  logic [STAT_W-1:0] STATUS_I,
    input  logic              DATA_VALID_I,
    output logic              DATA_READY_O,
    input  logic [DATA_W-1:0] DATA_I,
    output logic              OUT_VALID_O,
    input  logic              OUT_READY_I,
    output logic [DATA_W-1:0] OUT_DATA_O,
    output logic              OUT_LAST_O,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic              ERR_O,
    output logic [CNT_W-1:0]  WORDS_DONE_O
);

    // Every port pair is valid/ready: a transfer happens on a cycle where both are
    // high, and the valid side holds its payload stable until that cycle.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONFIG    = 3'd1,
        WAIT_TRIG = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES;

    state_t            state;
    state_t            state_next;
    logic [CTRL_W-1:0] control_q;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  words_done;
    logic [31:0]       timer;
    logic [31:0]       timer_inc;
    logic              err_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [DATA_W-1:0] out_data_q;

    logic cmd_ready;
    logic control_valid;
    logic status_ready;
    logic data_ready;
    logic trig_seen;
    logic timer_expired;
    logic buf_xfer;
    logic sink_xfer;
    logic unused_status;

    assign unused_status = ^STATUS_I;
    assign trig_seen     = STATUS_VALID_I && STATUS_I[TRIG_BIT];
    assign timer_inc     = timer + 32'd1;
    // The expiry test looks at the incremented count, so the last waiting cycle is
    // the TIMEOUT_CYCLES-th one after entering WAIT_TRIG.
    assign timer_expired = (TIMEOUT_LIMIT != 32'd0) && (timer_inc == TIMEOUT_LIMIT);
    assign buf_xfer      = data_ready && DATA_VALID_I;
    assign sink_xfer     = out_valid_q && OUT_READY_I;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        control_valid = 1'b0;
        status_ready  = 1'b0;
        data_ready    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (CMD_VALID_I) state_next = CONFIG;
            end
            CONFIG: begin
                control_valid = 1'b1;
                if (ABORT_I)              state_next = DONE;
                else if (CONTROL_READY_I) state_next = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                status_ready = 1'b1;
                if (ABORT_I)            state_next = DONE;
                else if (trig_seen)     state_next = (remaining != '0) ? DRAIN : DONE;
                else if (timer_expired) state_next = DONE;
            end
            DRAIN: begin
                data_ready = (remaining != '0) && (!out_valid_q || OUT_READY_I);
                if (ABORT_I)                      state_next = DONE;
                else if (sink_xfer && out_last_q) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            control_q   <= '0;
            remaining   <= '0;
            words_done  <= '0;
            timer       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID_I) begin
                        control_q  <= CMD_CONTROL_I;
                        remaining  <= CMD_WORDS_I;
                        words_done <= '0;
                        err_q      <= 1'b0;
                    end
                end
                CONFIG: begin
                    timer <= '0;
                    if (ABORT_I) err_q <= 1'b1;
                end
                WAIT_TRIG: begin
                    timer <= timer_inc;
                    if (ABORT_I || (!trig_seen && timer_expired)) err_q <= 1'b1;
                end
                DRAIN: begin
                    if (ABORT_I) begin
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end else begin
                        // A refill can only happen when the register is empty or being
                        // drained this cycle, so it overrides the sink-side clear.
                        if (buf_xfer) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= DATA_I;
                            out_last_q  <= (remaining == CNT_W'(1));
                            remaining   <= remaining - CNT_W'(1);
                        end else if (sink_xfer) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                        if (sink_xfer) words_done <= words_done + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign CMD_READY_O     = cmd_ready && !RST_I;
    assign CONTROL_VALID_O = control_valid && !RST_I;
    assign STATUS_READY_O  = status_ready && !RST_I;
    assign DATA_READY_O    = data_ready && !RST_I;
    assign OUT_VALID_O     = out_valid_q && !RST_I;
    assign CONTROL_O       = control_q;
    assign OUT_DATA_O      = out_data_q;
    assign OUT_LAST_O      = out_last_q;
    assign BUSY_O          = (state != IDLE);
    assign DONE_O          = (state == DONE) && !RST_I;
    assign ERR_O           = err_q;
    assign WORDS_DONE_O    = words_done;

endmodule

// File: tb/tb_trace_readout_sequencer.sv
// Bench for trace_readout_sequencer: directed capture/readout scenarios with a
// queue-based model of the drained stream checked on every cycle.
`timescale 1ns/1ps
module tb_trace_readout_sequencer;

    localparam int CTRL_W  = 8;
    localparam int STAT_W  = 8;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic RST_I = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic              CMD_VALID_I = 1'b0;
    logic              CMD_READY_O;
    logic [CTRL_W-1:0] CMD_CONTROL_I = '0;
    logic [CNT_W-1:0]  CMD_WORDS_I = '0;
    logic              ABORT_I = 1'b0;
    logic              CONTROL_VALID_O;
    logic              CONTROL_READY_I = 1'b0;
    logic [CTRL_W-1:0] CONTROL_O;
    logic              STATUS_VALID_I = 1'b0;
    logic              STATUS_READY_O;
    logic [STAT_W-1:0] STATUS_I = '0;
    logic              DATA_VALID_I = 1'b0;
    logic              DATA_READY_O;
    logic [DATA_W-1:0] DATA_I = '0;
    logic              OUT_VALID_O;
    logic              OUT_READY_I = 1'b1;
    logic [DATA_W-1:0] OUT_DATA_O;
    logic              OUT_LAST_O;
    logic              BUSY_O;
    logic              DONE_O;
    logic              ERR_O;
    logic [CNT_W-1:0]  WORDS_DONE_O;

    trace_readout_sequencer #(
        .CTRL_W(CTRL_W), .STAT_W(STAT_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .TRIG_BIT(0), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK_I(clk), .RST_I(RST_I),
        .CMD_VALID_I(CMD_VALID_I), .CMD_READY_O(CMD_READY_O),
        .CMD_CONTROL_I(CMD_CONTROL_I), .CMD_WORDS_I(CMD_WORDS_I), .ABORT_I(ABORT_I),
        .CONTROL_VALID_O(CONTROL_VALID_O), .CONTROL_READY_I(CONTROL_READY_I),
        .CONTROL_O(CONTROL_O),
        .STATUS_VALID_I(STATUS_VALID_I), .STATUS_READY_O(STATUS_READY_O),
        .STATUS_I(STATUS_I),
        .DATA_VALID_I(DATA_VALID_I), .DATA_READY_O(DATA_READY_O), .DATA_I(DATA_I),
        .OUT_VALID_O(OUT_VALID_O), .OUT_READY_I(OUT_READY_I),
        .OUT_DATA_O(OUT_DATA_O), .OUT_LAST_O(OUT_LAST_O),
        .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O), .WORDS_DONE_O(WORDS_DONE_O)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_last_q[$];
    int                model_words = 0;
    int                accepted = 0;
    int                popped = 0;
    int                ctrl_xfers = 0;
    int                status_xfers = 0;
    int                data_ready_cycles = 0;
    int                done_pulses = 0;
    logic              prev_done = 1'b0;
    logic [DATA_W-1:0] sink_data_log[$];
    int                sink_cyc_log[$];
    logic              sink_last_log[$];

    always @(negedge clk) begin
        if (RST_I) begin
            exp_q.delete();
            exp_last_q.delete();
            accepted  = 0;
            popped    = 0;
            prev_done = 1'b0;
        end else begin
            check("words_done", 64'(WORDS_DONE_O), 64'(popped));
            if (DONE_O) begin
                done_pulses++;
                check("done_width", 64'(prev_done), 64'(0));
            end
            prev_done = DONE_O;
            if (CONTROL_VALID_O && CONTROL_READY_I) ctrl_xfers++;
            if (STATUS_VALID_I && STATUS_READY_O) status_xfers++;
            if (DATA_READY_O) begin
                data_ready_cycles++;
                check("ready_remaining", 64'(accepted < model_words), 64'(1));
                check("ready_blocked", 64'((exp_q.size() == 0) || OUT_READY_I), 64'(1));
            end
            if (!ABORT_I && OUT_VALID_O && OUT_READY_I) begin
                sink_data_log.push_back(OUT_DATA_O);
                sink_cyc_log.push_back(cyc);
                sink_last_log.push_back(OUT_LAST_O);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sink_extra: got word %0h expected none", OUT_DATA_O);
                end else begin
                    check("sink_data", 64'(OUT_DATA_O), 64'(exp_q[0]));
                    check("sink_last", 64'(OUT_LAST_O), 64'(exp_last_q[0]));
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                popped++;
            end
            if (!ABORT_I && DATA_VALID_I && DATA_READY_O) begin
                exp_q.push_back(DATA_I);
                exp_last_q.push_back(accepted + 1 == model_words);
                accepted++;
            end
            if (CMD_VALID_I && CMD_READY_O) begin
                model_words = int'(CMD_WORDS_I);
                accepted    = 0;
                popped      = 0;
                exp_q.delete();
                exp_last_q.delete();
            end
        end
    end

    // ---------------- buffer data-out source ----------------
    logic [DATA_W-1:0] buf_q[$];
    logic              buf_take;
    initial begin
        forever begin
            @(negedge clk);
            buf_take = DATA_VALID_I && DATA_READY_O && !RST_I;
            @(posedge clk);
            #1;
            if (buf_take && buf_q.size() > 0) void'(buf_q.pop_front());
            DATA_VALID_I = (buf_q.size() > 0);
            DATA_I       = (buf_q.size() > 0) ? buf_q[0] : '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [CTRL_W-1:0] ctrl, input logic [CNT_W-1:0] words);
        logic ok;
        ok = 1'b0;
        CMD_CONTROL_I = ctrl;
        CMD_WORDS_I   = words;
        CMD_VALID_I   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (CMD_READY_O) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", 64'(ok), 64'(1));
        tick();
        CMD_VALID_I = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc, input int budget);
        logic ok;
        ok = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (DONE_O) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'(1));
        tick();
    endtask

    // Command plus immediate control-ready and trigger: lands in DRAIN (or DONE for 0 words).
    task automatic run_to_drain(input logic [CTRL_W-1:0] ctrl, input logic [CNT_W-1:0] words);
        CONTROL_READY_I = 1'b1;
        STATUS_VALID_I  = 1'b1;
        STATUS_I        = 8'h01;
        send_cmd(ctrl, words);
        tick();
        tick();
        CONTROL_READY_I = 1'b0;
        STATUS_VALID_I  = 1'b0;
        STATUS_I        = '0;
    endtask

    task automatic clear_logs();
        sink_data_log.delete();
        sink_cyc_log.delete();
        sink_last_log.delete();
    endtask

    // ---------------- directed scenarios ----------------
    logic [3:0] ready_pat = 4'b1001;
    int dc, entry, d0, dr0, n;
    logic ok;

    initial begin
        // reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_cmd_ready", 64'(CMD_READY_O), 64'(0));
        check("rst_ctrl_valid", 64'(CONTROL_VALID_O), 64'(0));
        check("rst_status_ready", 64'(STATUS_READY_O), 64'(0));
        check("rst_data_ready", 64'(DATA_READY_O), 64'(0));
        check("rst_out_valid", 64'(OUT_VALID_O), 64'(0));
        check("rst_done", 64'(DONE_O), 64'(0));
        check("rst_busy", 64'(BUSY_O), 64'(0));
        check("rst_err", 64'(ERR_O), 64'(0));
        check("rst_control", 64'(CONTROL_O), 64'(0));
        tick();
        RST_I = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(CMD_READY_O), 64'(1));
        check("idle_words_done", 64'(WORDS_DONE_O), 64'(0));
        tick();

        // config handshake held off 3 cycles, then status polling and a 4-word drain
        buf_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        clear_logs();
        ctrl_xfers   = 0;
        status_xfers = 0;
        d0           = done_pulses;
        send_cmd(8'hA5, 16'd4);
        CMD_VALID_I = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) CONTROL_READY_I = 1'b1;
            @(negedge clk);
            check("cfg_valid", 64'(CONTROL_VALID_O), 64'(1));
            check("cfg_word", 64'(CONTROL_O), 64'(8'hA5));
            check("busy_cmd_ready", 64'(CMD_READY_O), 64'(0));
            tick();
        end
        CONTROL_READY_I = 1'b0;
        CMD_VALID_I     = 1'b0;
        check("cfg_xfers", 64'(ctrl_xfers), 64'(1));
        for (int i = 0; i < 4; i++) begin
            STATUS_VALID_I = 1'b1;
            STATUS_I       = (i == 3) ? 8'h01 : 8'h00;
            @(negedge clk);
            check("poll_ready", 64'(STATUS_READY_O), 64'(1));
            if (i == 0) check("poll_ctrl_off", 64'(CONTROL_VALID_O), 64'(0));
            tick();
        end
        STATUS_VALID_I = 1'b0;
        STATUS_I       = '0;
        check("poll_xfers", 64'(status_xfers), 64'(4));
        wait_done(dc, 30);
        check("t2_count", 64'(sink_data_log.size()), 64'(4));
        if (sink_data_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_data", 64'(sink_data_log[i]), 64'(i + 1));
                check("t2_last", 64'(sink_last_log[i]), 64'(i == 3));
                check("t2_b2b", 64'(sink_cyc_log[i]), 64'(sink_cyc_log[0] + i));
            end
            check("t2_done_cyc", 64'(dc), 64'(sink_cyc_log[3] + 1));
        end
        check("t2_words_done", 64'(WORDS_DONE_O), 64'(4));
        check("t2_err", 64'(ERR_O), 64'(0));
        check("t2_pulses", 64'(done_pulses - d0), 64'(1));

        // sink backpressure 1,0,0,1,... over 6 words
        buf_q = '{32'd101, 32'd102, 32'd103, 32'd104, 32'd105, 32'd106};
        clear_logs();
        run_to_drain(8'h3C, 16'd6);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            OUT_READY_I = ready_pat[k % 4];
            @(negedge clk);
            if (OUT_VALID_O && !OUT_READY_I) check("bp_ready_low", 64'(DATA_READY_O), 64'(0));
            if (DONE_O) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("bp_done_seen", 64'(ok), 64'(1));
        tick();
        OUT_READY_I = 1'b1;
        check("bp_count", 64'(sink_data_log.size()), 64'(6));
        if (sink_data_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("bp_data", 64'(sink_data_log[i]), 64'(101 + i));
                check("bp_last", 64'(sink_last_log[i]), 64'(i == 5));
            end
        end
        check("bp_words_done", 64'(WORDS_DONE_O), 64'(6));

        // timeout: status words arrive but bit 0 never set
        dr0             = data_ready_cycles;
        CONTROL_READY_I = 1'b1;
        STATUS_VALID_I  = 1'b1;
        STATUS_I        = 8'hFE;
        send_cmd(8'h5A, 16'd2);
        entry = cyc + 1;
        wait_done(dc, 40);
        CONTROL_READY_I = 1'b0;
        STATUS_VALID_I  = 1'b0;
        STATUS_I        = '0;
        check("to_cycle", 64'(dc), 64'(entry + TIMEOUT));
        check("to_err", 64'(ERR_O), 64'(1));
        check("to_no_data_ready", 64'(data_ready_cycles), 64'(dr0));
        check("to_words_done", 64'(WORDS_DONE_O), 64'(0));

        // abort after 3 sink transfers of 8; ERR from timeout must clear on accept
        buf_q = '{32'd201, 32'd202, 32'd203, 32'd204, 32'd205, 32'd206, 32'd207, 32'd208};
        clear_logs();
        run_to_drain(8'h11, 16'd8);
        check("err_cleared", 64'(ERR_O), 64'(0));
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (OUT_VALID_O && OUT_READY_I) n++;
            if (n == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("ab_three_seen", 64'(ok), 64'(1));
        tick();
        ABORT_I = 1'b1;
        tick();
        ABORT_I = 1'b0;
        @(negedge clk);
        check("ab_done", 64'(DONE_O), 64'(1));
        check("ab_err", 64'(ERR_O), 64'(1));
        check("ab_out_valid", 64'(OUT_VALID_O), 64'(0));
        check("ab_words_done", 64'(WORDS_DONE_O), 64'(3));
        tick();
        @(negedge clk);
        check("ab_idle_out_valid", 64'(OUT_VALID_O), 64'(0));
        tick();
        buf_q.delete();

        // zero words: trigger goes straight to DONE, a pending buffer word is left alone
        buf_q = '{32'h55};
        clear_logs();
        dr0 = data_ready_cycles;
        d0  = done_pulses;
        run_to_drain(8'h22, 16'd0);
        wait_done(dc, 10);
        check("zw_no_sink", 64'(sink_data_log.size()), 64'(0));
        check("zw_no_ready", 64'(data_ready_cycles), 64'(dr0));
        check("zw_words_done", 64'(WORDS_DONE_O), 64'(0));
        check("zw_err", 64'(ERR_O), 64'(0));
        check("zw_pulses", 64'(done_pulses - d0), 64'(1));
        buf_q.delete();
        tick();

        // reset while DRAIN is stalled by the sink
        buf_q       = '{32'd301, 32'd302, 32'd303, 32'd304, 32'd305};
        OUT_READY_I = 1'b0;
        run_to_drain(8'h77, 16'd5);
        repeat (3) tick();
        check("rd_busy", 64'(BUSY_O), 64'(1));
        d0    = done_pulses;
        RST_I = 1'b1;
        @(negedge clk);
        check("rd_cmd_ready", 64'(CMD_READY_O), 64'(0));
        check("rd_ctrl_valid", 64'(CONTROL_VALID_O), 64'(0));
        check("rd_status_ready", 64'(STATUS_READY_O), 64'(0));
        check("rd_data_ready", 64'(DATA_READY_O), 64'(0));
        check("rd_out_valid", 64'(OUT_VALID_O), 64'(0));
        check("rd_done", 64'(DONE_O), 64'(0));
        tick();
        @(negedge clk);
        check("rd_busy_low", 64'(BUSY_O), 64'(0));
        check("rd_last", 64'(OUT_LAST_O), 64'(0));
        check("rd_control", 64'(CONTROL_O), 64'(0));
        check("rd_words_done", 64'(WORDS_DONE_O), 64'(0));
        tick();
        RST_I       = 1'b0;
        OUT_READY_I = 1'b1;
        buf_q.delete();
        repeat (4) tick();
        @(negedge clk);
        check("rd_idle_ready", 64'(CMD_READY_O), 64'(1));
        check("rd_idle_out_valid", 64'(OUT_VALID_O), 64'(0));
        check("rd_no_done", 64'(done_pulses), 64'(d0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
